video_timing_engine: RTL and testbench



---
 rtl/video_timing_engine_if.sv | 12 +
 rtl/video_timing_engine.sv | 230 +++++++++++++++++++++++
 tb/tb_video_timing_engine.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_engine_if.sv
// Framebuffer read port: the raster engine drives address/strobe (master),
// the framebuffer returns pixel data PIPE cycles later (slave).
interface video_timing_engine_if #(
    parameter int ADDR_W = 19
);
    logic [ADDR_W-1:0] rdAddr;
    logic              rdEn;
    logic [23:0]       pixIn;

    modport master (output rdAddr, output rdEn, input pixIn);
    modport slave  (input rdAddr, input rdEn, output pixIn);
endinterface

// File: rtl/video_timing_engine.sv
// Raster timing engine: stage-0 counters with increment-only framebuffer addressing,
// a PIPE-deep delay line matching framebuffer latency, and an aligned output register.
module video_timing_engine #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIPE     = 2,
    parameter int ADDR_W   = $clog2(H_ACTIVE * V_ACTIVE)
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         en,
    input  logic [1:0]                                   mode,
    input  logic [23:0]                                  solid,
    video_timing_engine_if.master                        fb,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0] sx,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0] sy,
    output logic                                         hsyncOut,
    output logic                                         vsyncOut,
    output logic                                         deOut,
    output logic [23:0]                                  pixOut,
    output logic                                         frameStart
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic        fb;
        logic [23:0] pix;
    } stage_t;

    logic [HW-1:0]     sx_q, sx_d;
    logic [VW-1:0]     sy_q, sy_d;
    logic              run_q, run_d;
    logic              de0_q, de0_d, hs0_q, hs0_d, vs0_q, vs0_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [1:0]        mode_q, mode_d;
    logic [23:0]       solid_q, solid_d;
    logic [BW-1:0]     bar_cnt_q, bar_cnt_d;
    logic [2:0]        bar_idx_q, bar_idx_d;
    logic              origin;
    logic              chk_x, chk_y;
    logic [23:0]       pat;
    stage_t            dl_q [PIPE];
    stage_t            dl_d [PIPE];
    stage_t            tail;
    logic              hsync_out_q, hsync_out_d, vsync_out_q, vsync_out_d;
    logic              de_out_q, de_out_d, fs_out_q, fs_out_d;
    logic [23:0]       pix_out_q, pix_out_d;

    // Small rasters may have fewer than four counter bits; the missing bit is always zero.
    if (HW > 3) begin : g_chk_x
        assign chk_x = sx_q[3];
    end else begin : g_chk_x0
        assign chk_x = 1'b0;
    end
    if (VW > 3) begin : g_chk_y
        assign chk_y = sy_q[3];
    end else begin : g_chk_y0
        assign chk_y = 1'b0;
    end

    always_comb begin
        sx_d   = '0;
        sy_d   = '0;
        run_d  = 1'b0;
        if (en) begin
            run_d = 1'b1;
            if (run_q) begin
                if (sx_q == H_LAST) begin
                    sy_d = (sy_q == V_LAST) ? '0 : sy_q + VW'(1);
                end else begin
                    sx_d = sx_q + HW'(1);
                    sy_d = sy_q;
                end
            end
        end
        origin = run_d && (sx_d == '0) && (sy_d == '0);
        de0_d  = run_d && (sx_d < H_ACT) && (sy_d < V_ACT);
        hs0_d  = run_d && (sx_d >= HS_FIRST) && (sx_d <= HS_LAST);
        vs0_d  = run_d && (sy_d >= VS_FIRST) && (sy_d <= VS_LAST);

        rd_addr_d = rd_addr_q;
        if (!en || origin) begin
            rd_addr_d = '0;
        end else if (de0_d) begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
        end

        mode_d  = mode_q;
        solid_d = solid_q;
        if (!en || origin) begin
            mode_d  = mode;
            solid_d = solid;
        end

        // Bar index advances every BAR_W pixels, avoiding a divide by H_ACTIVE/8.
        bar_cnt_d = '0;
        bar_idx_d = '0;
        if (sx_d != '0) begin
            if (bar_cnt_q == BAR_LAST) begin
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_cnt_d = bar_cnt_q + BW'(1);
                bar_idx_d = bar_idx_q;
            end
        end
    end

    always_comb begin
        pat = 24'h000000;
        case (mode_q)
            2'd1: pat = solid_q;
            2'd2: begin
                case (bar_idx_q)
                    3'd0: pat = 24'hFFFFFF;
                    3'd1: pat = 24'hFFFF00;
                    3'd2: pat = 24'h00FFFF;
                    3'd3: pat = 24'h00FF00;
                    3'd4: pat = 24'hFF00FF;
                    3'd5: pat = 24'hFF0000;
                    3'd6: pat = 24'h0000FF;
                    default: pat = 24'h000000;
                endcase
            end
            2'd3: pat = (chk_x ^ chk_y) ? 24'hFFFFFF : 24'h000000;
            default: pat = 24'h000000;
        endcase
        dl_d[0].de  = de0_q;
        dl_d[0].hs  = hs0_q;
        dl_d[0].vs  = vs0_q;
        dl_d[0].fs  = de0_q && (sx_q == '0) && (sy_q == '0);
        dl_d[0].fb  = (mode_q == 2'd0);
        dl_d[0].pix = pat;
        for (int i = 1; i < PIPE; i++) begin
            dl_d[i] = dl_q[i-1];
        end
    end

    always_comb begin
        tail        = dl_q[PIPE-1];
        hsync_out_d = tail.hs ? HS_POL : ~HS_POL;
        vsync_out_d = tail.vs ? VS_POL : ~VS_POL;
        de_out_d    = tail.de;
        fs_out_d    = tail.fs;
        pix_out_d   = 24'h000000;
        if (tail.de) begin
            pix_out_d = tail.fb ? fb.pixIn : tail.pix;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sx_q        <= '0;
            sy_q        <= '0;
            run_q       <= 1'b0;
            de0_q       <= 1'b0;
            hs0_q       <= 1'b0;
            vs0_q       <= 1'b0;
            rd_addr_q   <= '0;
            mode_q      <= 2'd0;
            solid_q     <= 24'h000000;
            bar_cnt_q   <= '0;
            bar_idx_q   <= '0;
            for (int i = 0; i < PIPE; i++) begin
                dl_q[i] <= '0;
            end
            hsync_out_q <= ~HS_POL;
            vsync_out_q <= ~VS_POL;
            de_out_q    <= 1'b0;
            fs_out_q    <= 1'b0;
            pix_out_q   <= 24'h000000;
        end else begin
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            run_q       <= run_d;
            de0_q       <= de0_d;
            hs0_q       <= hs0_d;
            vs0_q       <= vs0_d;
            rd_addr_q   <= rd_addr_d;
            mode_q      <= mode_d;
            solid_q     <= solid_d;
            bar_cnt_q   <= bar_cnt_d;
            bar_idx_q   <= bar_idx_d;
            for (int i = 0; i < PIPE; i++) begin
                dl_q[i] <= dl_d[i];
            end
            hsync_out_q <= hsync_out_d;
            vsync_out_q <= vsync_out_d;
            de_out_q    <= de_out_d;
            fs_out_q    <= fs_out_d;
            pix_out_q   <= pix_out_d;
        end
    end

    assign sx         = sx_q;
    assign sy         = sy_q;
    assign fb.rdAddr  = rd_addr_q;
    assign fb.rdEn    = de0_q;
    assign hsyncOut   = hsync_out_q;
    assign vsyncOut   = vsync_out_q;
    assign deOut      = de_out_q;
    assign pixOut     = pix_out_q;
    assign frameStart = fs_out_q;
endmodule

// File: tb/tb_video_timing_engine.sv
// Bench for video_timing_engine: a small raster and a default raster run side by side,
// each compared every cycle against a raster-position reference model.
module tb_video_timing_engine;
    localparam int PIPE = 2;

    typedef struct {
        bit          de;
        bit          hs;
        bit          vs;
        bit          fs;
        logic [23:0] pix;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [23:0] solid;

    always #5 clk = ~clk;

    video_timing_engine_if #(.ADDR_W(6))  fbS ();
    video_timing_engine_if #(.ADDR_W(19)) fbD ();

    logic [4:0]  sxS;
    logic [2:0]  syS;
    logic [9:0]  sxD, syD;
    logic        hsS, vsS, deS, fsS, hsD, vsD, deD, fsD;
    logic [23:0] pixS, pixD;

    video_timing_engine #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIPE(PIPE), .ADDR_W(6)
    ) dutS (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .solid(solid), .fb(fbS),
        .sx(sxS), .sy(syS), .hsyncOut(hsS), .vsyncOut(vsS), .deOut(deS),
        .pixOut(pixS), .frameStart(fsS)
    );

    video_timing_engine dutD (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .solid(solid), .fb(fbD),
        .sx(sxD), .sy(syD), .hsyncOut(hsD), .vsyncOut(vsD), .deOut(deD),
        .pixOut(pixD), .frameStart(fsD)
    );

    function automatic logic [23:0] fbWord(input int a);
        logic [23:0] w;
        w = 24'(a);
        return w ^ (w << 11) ^ 24'h3C5A96;
    endfunction

    // Framebuffer stand-in with a two-cycle read latency.
    logic [23:0] fbS1, fbD1;
    always @(posedge clk) begin
        fbS1      <= fbWord(32'(fbS.rdAddr));
        fbS.pixIn <= fbS1;
        fbD1      <= fbWord(32'(fbD.rdAddr));
        fbD.pixIn <= fbD1;
    end

    int          cHA [2] = '{16, 640};
    int          cHF [2] = '{2, 16};
    int          cHS [2] = '{3, 96};
    int          cHB [2] = '{3, 48};
    int          cVA [2] = '{4, 480};
    int          cVF [2] = '{1, 10};
    int          cVS [2] = '{2, 2};
    int          cVB [2] = '{1, 33};
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    bit          run [2];
    int          pos [2];
    logic [1:0]  shMode [2];
    logic [23:0] shSolid [2];
    rec_t        histS [$];
    rec_t        histD [$];
    rec_t        cur [2];
    int          expSx [2], expSy [2], expAddr [2];
    bit          expRdEn [2];

    int checks = 0;
    int errors = 0;
    int rnd, firstFs, period;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic [1:0] m, input logic [23:0] s);
        en    = e;
        mode  = m;
        solid = s;
    endtask

    task automatic resetModel(input int d);
        rec_t idle;
        idle.de = 0; idle.hs = 0; idle.vs = 0; idle.fs = 0; idle.pix = 24'h0;
        run[d] = 0; pos[d] = 0; shMode[d] = 2'd0; shSolid[d] = 24'h0;
        expSx[d] = 0; expSy[d] = 0; expAddr[d] = 0; expRdEn[d] = 0;
        cur[d] = idle;
        if (d == 0) begin
            histS.delete();
            for (int i = 0; i <= PIPE; i++) histS.push_back(idle);
        end else begin
            histD.delete();
            for (int i = 0; i <= PIPE; i++) histD.push_back(idle);
        end
    endtask

    // Model works from the linear position in the frame; address is the row-major index
    // of the most recent active pixel, and output is the stage-0 record PIPE+1 edges old.
    task automatic modelEdge(input int d);
        int   ht, vt, x, y, a;
        rec_t r;
        if (rst) begin
            resetModel(d);
            return;
        end
        ht = cHA[d] + cHF[d] + cHS[d] + cHB[d];
        vt = cVA[d] + cVF[d] + cVS[d] + cVB[d];
        if (!en) begin
            run[d] = 0; pos[d] = 0;
        end else if (!run[d]) begin
            run[d] = 1; pos[d] = 0;
        end else begin
            pos[d] = (pos[d] + 1) % (ht * vt);
        end
        if (!en || pos[d] == 0) begin
            shMode[d] = mode; shSolid[d] = solid;
        end
        x = pos[d] % ht;
        y = pos[d] / ht;
        r.de = run[d] && x < cHA[d] && y < cVA[d];
        r.hs = run[d] && x >= cHA[d] + cHF[d] && x < cHA[d] + cHF[d] + cHS[d];
        r.vs = run[d] && y >= cVA[d] + cVF[d] && y < cVA[d] + cVF[d] + cVS[d];
        r.fs = r.de && x == 0 && y == 0;
        if (!run[d])            a = 0;
        else if (y >= cVA[d])   a = cHA[d] * cVA[d] - 1;
        else if (x >= cHA[d])   a = y * cHA[d] + cHA[d] - 1;
        else                    a = y * cHA[d] + x;
        r.pix = 24'h0;
        if (r.de) begin
            case (shMode[d])
                2'd0: r.pix = fbWord(a);
                2'd1: r.pix = shSolid[d];
                2'd2: r.pix = bars[x / (cHA[d] / 8)];
                default: r.pix = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            endcase
        end
        expSx[d] = x; expSy[d] = y; expAddr[d] = a; expRdEn[d] = r.de;
        if (d == 0) begin
            histS.push_back(r);
            cur[0] = histS.pop_front();
        end else begin
            histD.push_back(r);
            cur[1] = histD.pop_front();
        end
    endtask

    task automatic checkAll();
        checkOutput("S.sx", 32'(sxS), 32'(expSx[0]));
        checkOutput("S.sy", 32'(syS), 32'(expSy[0]));
        checkOutput("S.rdEn", 32'(fbS.rdEn), 32'(expRdEn[0]));
        checkOutput("S.rdAddr", 32'(fbS.rdAddr), 32'(expAddr[0]));
        checkOutput("S.hsync", 32'(hsS), cur[0].hs ? 32'd0 : 32'd1);
        checkOutput("S.vsync", 32'(vsS), cur[0].vs ? 32'd0 : 32'd1);
        checkOutput("S.de", 32'(deS), 32'(cur[0].de));
        checkOutput("S.frameStart", 32'(fsS), 32'(cur[0].fs));
        checkOutput("S.pix", 32'(pixS), 32'(cur[0].pix));
        checkOutput("D.sx", 32'(sxD), 32'(expSx[1]));
        checkOutput("D.sy", 32'(syD), 32'(expSy[1]));
        checkOutput("D.rdEn", 32'(fbD.rdEn), 32'(expRdEn[1]));
        checkOutput("D.rdAddr", 32'(fbD.rdAddr), 32'(expAddr[1]));
        checkOutput("D.hsync", 32'(hsD), cur[1].hs ? 32'd0 : 32'd1);
        checkOutput("D.vsync", 32'(vsD), cur[1].vs ? 32'd0 : 32'd1);
        checkOutput("D.de", 32'(deD), 32'(cur[1].de));
        checkOutput("D.frameStart", 32'(fsD), 32'(cur[1].fs));
        checkOutput("D.pix", 32'(pixD), 32'(cur[1].pix));
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelEdge(0);
        modelEdge(1);
        @(negedge clk);
        checkAll();
    endtask

    // Reset lands between clock edges; outputs must clear before any further edge.
    task automatic applyReset();
        @(posedge clk);
        modelEdge(0);
        modelEdge(1);
        #2 rst = 1'b1;
        #1;
        resetModel(0);
        resetModel(1);
        checkOutput("S.rstHsync", 32'(hsS), 32'd1);
        checkOutput("S.rstVsync", 32'(vsS), 32'd1);
        checkOutput("S.rstDe", 32'(deS), 32'd0);
        checkOutput("S.rstAddr", 32'(fbS.rdAddr), 32'd0);
        checkOutput("S.rstPix", 32'(pixS), 32'd0);
        checkOutput("D.rstHsync", 32'(hsD), 32'd1);
        checkOutput("D.rstVsync", 32'(vsD), 32'd1);
        checkOutput("D.rstDe", 32'(deD), 32'd0);
        checkOutput("D.rstAddr", 32'(fbD.rdAddr), 32'd0);
        checkOutput("D.rstSx", 32'(sxD), 32'd0);
        @(negedge clk);
        checkAll();
        repeat (2) stepCycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 2'd2, 24'h000000);
        resetModel(0);
        resetModel(1);
        repeat (2) stepCycle();
        $display("[TB] colour bars from reset release");
        applyStimulus(1'b1, 2'd2, 24'h000000);
        rst = 1'b0;
        repeat (900) stepCycle();

        $display("[TB] mid-line reset, then framebuffer mode");
        applyReset();
        applyStimulus(1'b1, 2'd0, 24'h000000);
        repeat (600) stepCycle();

        firstFs = -1;
        period  = -1;
        for (int i = 0; i < 500 && period < 0; i++) begin
            stepCycle();
            if (fsS === 1'b1) begin
                if (firstFs < 0) firstFs = i;
                else period = i - firstFs;
            end
        end
        checkOutput("S.framePeriod", 32'(period), 32'd192);

        $display("[TB] mid-frame switch to solid");
        for (int i = 0; i < 400 && expSy[0] != 2; i++) stepCycle();
        applyStimulus(1'b1, 2'd1, 24'h123456);
        repeat (400) stepCycle();

        $display("[TB] scan enable dropped mid-frame");
        applyStimulus(1'b1, 2'd0, 24'h123456);
        repeat (200) stepCycle();
        for (int i = 0; i < 400 && expSy[0] != 1; i++) stepCycle();
        applyStimulus(1'b0, 2'd0, 24'h123456);
        repeat (50) stepCycle();
        applyStimulus(1'b1, 2'd0, 24'h123456);
        repeat (300) stepCycle();

        $display("[TB] randomised run");
        for (int i = 0; i < 5000; i++) begin
            rnd = int'($urandom_range(0, 999));
            if (rnd < 4) begin
                applyStimulus(en, 2'($urandom_range(0, 3)), 24'($urandom));
            end else if (rnd < 7) begin
                applyStimulus(1'b0, mode, solid);
                repeat ($urandom_range(1, 60)) stepCycle();
                applyStimulus(1'b1, mode, solid);
            end else if (rnd == 7) begin
                applyReset();
            end
            stepCycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
